// File: rtl/lfsr_msg_scheduler.sv
// lfsr_msg_scheduler: shares one 64-bit XNOR LFSR message generator between
// NUM_REQ requesters. A seed and message total are loaded on start. After
// that, one message per cycle is granted round-robin until the total has
// been issued. Then done is flagged.
// Optional build macro SCHED_PERREQ_CNT_EN adds per-requester grant
// counters on output req_cnt.
module lfsr_msg_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [63:0]              message_seed,
  input  logic [CNT_W-1:0]         total_msgs,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [63:0]              msg_out,
  output logic [CNT_W-1:0]         issued,
  output logic                     busy,
`ifdef SCHED_PERREQ_CNT_EN
  output logic                     done,
  output logic [NUM_REQ*CNT_W-1:0] req_cnt
`else
  output logic                     done
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);
  localparam logic [PW-1:0]      PTR_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [63:0]        r_seed;
  logic [CNT_W-1:0]   r_total;
  logic [63:0]        r_lfsr;
  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [63:0]        r_msg;
  logic [CNT_W-1:0]   r_issued;
  logic               w_found;
  logic [PW-1:0]      w_win;
  logic               w_grant;
  logic               w_accept;
  logic [63:0]        w_lfsr_next;

  // XNOR feedback with taps 64,63,61,60. All-ones is the lock-up state.
  assign w_lfsr_next = {r_lfsr[62:0], ~(r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59])};

  // Round-robin search: first set req bit at or above the pointer, wrapping.
  always_comb begin : arb
    int            idx;
    logic [PW-1:0] sel;
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PW'(idx);
      if (!w_found && req[sel]) begin
        w_found = 1'b1;
        w_win   = sel;
      end
    end
  end

  // Next-state logic, start acceptance, and the grant decision.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: w_state_next = (r_total == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (w_found && (r_issued < r_total)) begin
          w_grant = 1'b1;
          if ((r_issued + CNT_W'(1)) == r_total) w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath: capture on start, load the LFSR, issue one message per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seed   <= '0;
      r_total  <= '0;
      r_lfsr   <= '0;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_msg    <= '0;
      r_issued <= '0;
    end else begin
      r_gnt <= '0;
      if (w_accept) begin
        r_seed  <= message_seed;
        r_total <= total_msgs;
      end
      if (r_state == S_LOAD) begin
        r_lfsr   <= r_seed;
        r_issued <= '0;
      end
      if (w_grant) begin
        r_gnt    <= GNT_ONE << w_win;
        r_msg    <= r_lfsr;
        r_lfsr   <= w_lfsr_next;
        r_issued <= r_issued + CNT_W'(1);
        r_ptr    <= (w_win == PTR_LAST) ? '0 : w_win + PW'(1);
      end
    end
  end

  assign gnt     = r_gnt;
  assign msg_out = r_msg;
  assign issued  = r_issued;
  assign busy    = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done    = (r_state == S_DONE);

`ifdef SCHED_PERREQ_CNT_EN
  logic [CNT_W-1:0] r_req_cnt [NUM_REQ];

  // Per-requester grant counters, cleared on each load.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this small counter array is flop-based and must start at zero,
    // so it is reset element by element; a RAM would not be.
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_req_cnt[i] <= '0;
    end else if (r_state == S_LOAD) begin
      for (int i = 0; i < NUM_REQ; i++) r_req_cnt[i] <= '0;
    end else if (w_grant) begin
      r_req_cnt[w_win] <= r_req_cnt[w_win] + CNT_W'(1);
    end
  end

  // Flatten the counters, slice i belonging to requester i.
  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) req_cnt[i*CNT_W +: CNT_W] = r_req_cnt[i];
  end
`endif

endmodule

// File: tb/tb_lfsr_msg_scheduler.sv
// Testbench for lfsr_msg_scheduler: directed scenarios with hand-computed
// expectations, plus a cycle-level behavioural model checked every cycle.
module tb_lfsr_msg_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 32;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [63:0]          seed;
  logic [CNT_W-1:0]     total;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic [63:0]          msg_out;
  logic [CNT_W-1:0]     issued;
  logic                 busy;
  logic                 done;
`ifdef SCHED_PERREQ_CNT_EN
  logic [NUM_REQ*CNT_W-1:0] req_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_msg_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .message_seed(seed), .total_msgs(total),
    .req(req), .gnt(gnt), .msg_out(msg_out), .issued(issued), .busy(busy),
`ifdef SCHED_PERREQ_CNT_EN
    .done(done), .req_cnt(req_cnt)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    return {x[62:0], ~(x[63] ^ x[62] ^ x[60] ^ x[59])};
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_LOAD, PH_RUN, PH_DONE} phase_t;
  phase_t           m_phase;
  logic [63:0]      m_seed, m_lfsr;
  int unsigned      m_total;
  int               m_last;
  int unsigned      m_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] e_gnt;
  logic [63:0]      e_msg;
  int unsigned      e_issued;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = PH_IDLE; m_seed = '0; m_lfsr = '0; m_total = 0;
      m_last = NUM_REQ - 1; e_gnt = '0; e_msg = '0; e_issued = 0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else begin
      e_gnt = '0;
      case (m_phase)
        PH_IDLE, PH_DONE: if (start) begin
          m_seed = seed; m_total = total; m_phase = PH_LOAD;
        end
        PH_LOAD: begin
          m_lfsr = m_seed; e_issued = 0;
          for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
          m_phase = (m_total == 0) ? PH_DONE : PH_RUN;
        end
        PH_RUN: if (req != '0 && e_issued < m_total) begin
          int w;
          w = -1;
          // winner: first requester after the last one served, cyclically
          for (int k = 1; k <= NUM_REQ; k++)
            if (w < 0 && req[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
          e_gnt[w] = 1'b1;
          e_msg = m_lfsr;
          m_lfsr = lfsr_step(m_lfsr);
          e_issued++;
          m_cnt[w]++;
          m_last = w;
          if (e_issued == m_total) m_phase = PH_DONE;
        end
        default: ;
      endcase
    end
  end

  // Compare DUT outputs with the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("msg_out", msg_out, e_msg);
      check("issued", 64'(issued), 64'(e_issued));
      check("busy", 64'(busy), 64'(m_phase == PH_LOAD || m_phase == PH_RUN));
      check("done", 64'(done), 64'(m_phase == PH_DONE));
      check("gnt_onehot0", 64'($countones(gnt) <= 1), 64'(1));
`ifdef SCHED_PERREQ_CNT_EN
      for (int i = 0; i < NUM_REQ; i++)
        check("req_cnt_slice", 64'(req_cnt[i*CNT_W +: CNT_W]), 64'(m_cnt[i]));
`endif
    end
  end

  // Grant log for directed literal checks.
  int          cyc = 0;
  int          log_idx [$];
  logic [63:0] log_msg [$];
  int          log_cyc [$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst && gnt != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) log_idx.push_back(i);
      log_msg.push_back(msg_out);
      log_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    log_idx.delete(); log_msg.delete(); log_cyc.delete();
  endtask

  // Pulse start for one cycle; returns at the falling edge after LOAD is entered.
  task automatic do_start(input logic [63:0] s, input logic [CNT_W-1:0] t);
    @(negedge clk);
    start = 1'b1; seed = s; total = t;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done !== 1'b1; k++) @(negedge clk);
    check("done_reached", 64'(done), 64'(1));
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int k = 0; k < budget && log_idx.size() < n; k++) @(negedge clk);
    check("grants_reached", 64'(log_idx.size() >= n), 64'(1));
  endtask

  logic [63:0] exp_m;
  int          n0;
  int          order3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; total = '0; req = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_msg", msg_out, 64'(0));
    check("rst_issued", 64'(issued), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst = 1'b0;

    // Seed 0, total 4, single requester: 0,1,3,7 back to back.
    req = 4'b0001; clear_log();
    do_start(64'h0, 4);
    wait_done(20);
    check("t1_count", 64'(log_idx.size()), 64'(4));
    if (log_idx.size() == 4) begin
      check("t1_m0", log_msg[0], 64'h0);
      check("t1_m1", log_msg[1], 64'h1);
      check("t1_m2", log_msg[2], 64'h3);
      check("t1_m3", log_msg[3], 64'h7);
      check("t1_idx", 64'(log_idx[0] + log_idx[1] + log_idx[2] + log_idx[3]), 64'(0));
      check("t1_consecutive", 64'(log_cyc[3] - log_cyc[0]), 64'(3));
    end
    @(negedge clk);
    check("t1_gnt_after", 64'(gnt), 64'(0));
    check("t1_issued", 64'(issued), 64'(4));
    check("t1_done", 64'(done), 64'(1));

    // All-ones seed is the XNOR lock-up state: it repeats.
    clear_log();
    do_start(ONES, 2);
    wait_done(20);
    check("t2_count", 64'(log_idx.size()), 64'(2));
    if (log_idx.size() == 2) begin
      check("t2_m0", log_msg[0], ONES);
      check("t2_m1", log_msg[1], ONES);
    end

    // Fresh pointer, all requesting: strict rotation 0,1,2,3,0,1,2,3.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 4'b1111; clear_log();
    do_start(64'h0123_4567_89AB_CDEF, 8);
    wait_done(30);
    check("t3_count", 64'(log_idx.size()), 64'(8));
    if (log_idx.size() == 8)
      for (int i = 0; i < 8; i++) check("t3_order", 64'(log_idx[i]), 64'(order3[i]));
`ifdef SCHED_PERREQ_CNT_EN
    for (int i = 0; i < NUM_REQ; i++) check("t3_req_cnt", 64'(req_cnt[i*CNT_W +: CNT_W]), 64'(2));
`endif

    // Total 0: LOAD then DONE, never a grant.
    clear_log();
    do_start(64'h55, 0);
    check("t4_busy_load", 64'(busy), 64'(1));
    check("t4_not_done", 64'(done), 64'(0));
    @(negedge clk);
    check("t4_done", 64'(done), 64'(1));
    check("t4_issued", 64'(issued), 64'(0));
    repeat (3) @(negedge clk);
    check("t4_no_grants", 64'(log_idx.size()), 64'(0));

    // Total 10 with a 3-cycle request gap; two requesters alternate.
    req = 4'b0101; clear_log();
    do_start(64'hDEAD_BEEF_0000_0001, 10);
    repeat (4) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    n0 = log_idx.size();
    check("t5_pre_gap", 64'(n0), 64'(3));
    check("t5_gap_gnt", 64'(gnt), 64'(0));
    repeat (2) @(negedge clk);
    check("t5_gap_frozen", 64'(log_idx.size()), 64'(n0));
    check("t5_gap_issued", 64'(issued), 64'(3));
    req = 4'b0101;
    wait_done(40);
    check("t5_issued", 64'(issued), 64'(10));
    check("t5_count", 64'(log_idx.size()), 64'(10));
    if (log_idx.size() == 10) begin
      exp_m = 64'hDEAD_BEEF_0000_0001;
      for (int i = 0; i < 10; i++) begin
        check("t5_msg_seq", log_msg[i], exp_m);
        check("t5_alternate", 64'(log_idx[i]), 64'((i % 2) ? 2 : 0));
        exp_m = lfsr_step(exp_m);
      end
    end

    // Async reset mid-run, then restart; a start pulse during RUN is ignored.
    req = 4'b0001; clear_log();
    do_start(64'h0, 10);
    wait_log(3, 20);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_gnt", 64'(gnt), 64'(0));
    check("t6_rst_msg", msg_out, 64'(0));
    check("t6_rst_issued", 64'(issued), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    do_start(64'h0, 5);
    wait_log(2, 20);
    do_start(ONES, 1);
    wait_done(20);
    check("t6_issued", 64'(issued), 64'(5));
    check("t6_count", 64'(log_idx.size()), 64'(5));
    if (log_idx.size() == 5) begin
      check("t6_first", log_msg[0], 64'h0);
      check("t6_last", log_msg[4], 64'hF);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
